// File: rtl/pad_attr_sequencer.sv
// pad_attr_sequencer: WARL-masked pad attribute registers with a glitch-safe
// quiesce/apply/settle update sequence per write that changes a pad's value.
module pad_attr_sequencer #(
    parameter int NumPads       = 8,
    parameter int AttrW         = 16,
    parameter int QuiesceCycles = 2,
    parameter int SettleCycles  = 4,
    localparam int IdxW         = $clog2(NumPads)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [IdxW-1:0]          req_idx_i,
    input  logic [AttrW-1:0]         req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [AttrW-1:0]         rsp_rdata_o,
    output logic                     rsp_err_o,
    input  logic [NumPads*AttrW-1:0] warl_i,
    output logic [NumPads*AttrW-1:0] attr_o,
    output logic [NumPads-1:0]       quiesce_o,
    output logic                     busy_o
);
    localparam int MaxCycles = QuiesceCycles > SettleCycles ? QuiesceCycles : SettleCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [1:0] {IDLE, QUIESCE, APPLY, SETTLE} state_t;

    state_t                          r_state, w_state_d;
    logic [CntW-1:0]                 r_cnt, w_cnt_d;
    logic [IdxW-1:0]                 r_idx;
    logic [AttrW-1:0]                r_data;
    logic [NumPads-1:0][AttrW-1:0]   r_attr;
    logic [NumPads-1:0]              r_quiesce;
    logic                            r_rsp_valid, r_rsp_err;
    logic [AttrW-1:0]                r_rsp_rdata;
    logic [NumPads-1:0][AttrW-1:0]   w_warl;
    logic [AttrW-1:0]                w_masked;
    logic                            w_accept, w_in_range, w_seq_start, w_done;

    assign w_warl      = warl_i;
    assign req_ready_o = r_state == IDLE;
    assign busy_o      = !req_ready_o;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_in_range  = {1'b0, req_idx_i} < (IdxW + 1)'(NumPads);
    assign w_masked    = req_wdata_i & w_warl[req_idx_i];
    assign w_seq_start = w_accept && w_in_range && req_we_i && (w_masked != r_attr[req_idx_i]);

    assign attr_o      = r_attr;
    assign quiesce_o   = r_quiesce;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_seq_start) begin
                    w_state_d = QUIESCE;
                    w_cnt_d   = CntW'(QuiesceCycles - 1);
                end
            end
            QUIESCE: begin
                if (r_cnt == '0) w_state_d = APPLY;
                else             w_cnt_d   = r_cnt - 1'b1;
            end
            APPLY: begin
                if (SettleCycles == 0) begin
                    w_state_d = IDLE;
                    w_done    = 1'b1;
                end else begin
                    w_state_d = SETTLE;
                    w_cnt_d   = CntW'(SettleCycles - 1);
                end
            end
            default: begin
                if (r_cnt == '0) begin
                    w_state_d = IDLE;
                    w_done    = 1'b1;
                end else begin
                    w_cnt_d   = r_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_attr      <= '0;
            r_quiesce   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_rsp_valid <= (w_accept && !w_seq_start) || w_done;
            r_rsp_err   <= w_accept && !w_in_range;
            r_rsp_rdata <= (w_accept && w_in_range && !req_we_i) ? r_attr[req_idx_i] : '0;
            if (w_seq_start) begin
                r_idx              <= req_idx_i;
                r_data             <= w_masked;
                r_quiesce[req_idx_i] <= 1'b1;
            end
            if (r_state == APPLY) r_attr[r_idx] <= r_data;
            // Quiesce drops on the same edge that returns to IDLE and raises the response.
            if (w_done) r_quiesce[r_idx] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pad_attr_sequencer.sv
// tb_pad_attr_sequencer: directed checks of reads, masked writes, fast path,
// out-of-range errors, backpressure, WARL capture and reset mid-sequence.
module tb_pad_attr_sequencer;
    localparam int NP = 6;
    localparam int AW = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [2:0]        req_idx_i = '0;
    logic [AW-1:0]     req_wdata_i = '0;
    logic              rsp_valid_o;
    logic [AW-1:0]     rsp_rdata_o;
    logic              rsp_err_o;
    logic [NP-1:0][AW-1:0] warl = '0;
    logic [NP*AW-1:0]  attr_o;
    logic [NP-1:0][AW-1:0] attr_w;
    logic [NP-1:0]     quiesce_o;
    logic              busy_o;
    logic [NP*AW-1:0]  saved_attr;
    int checks = 0;
    int errors = 0;

    assign attr_w = attr_o;

    pad_attr_sequencer #(.NumPads(NP), .AttrW(AW), .QuiesceCycles(2), .SettleCycles(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_idx_i(req_idx_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .warl_i(warl), .attr_o(attr_o), .quiesce_o(quiesce_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: presents a request for one cycle (cycle 0), returns in cycle 1.
    task automatic req(input logic we, input logic [2:0] idx, input logic [AW-1:0] data);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_idx_i   = idx;
        req_wdata_i = data;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    initial begin
        warl[2] = 16'h0003;
        warl[4] = 16'h00FF;
        warl[5] = 16'hFFFF;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_attr", attr_o, '0);
        check("rst_quiesce", quiesce_o, '0);
        check("rst_ready", req_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);

        req(1'b0, 3'd3, '0);
        @(negedge clk_i);
        check("rd3_valid", rsp_valid_o, 1'b1);
        check("rd3_rdata", rsp_rdata_o, 16'h0000);
        check("rd3_err", rsp_err_o, 1'b0);
        @(negedge clk_i);
        check("rd3_pulse", rsp_valid_o, 1'b0);

        req(1'b1, 3'd2, 16'hFFFF);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            check($sformatf("wr2_quiesce_c%0d", c), quiesce_o, (c <= 7) ? 6'b000100 : 6'b000000);
            check($sformatf("wr2_attr_c%0d", c), attr_w[2], (c >= 4) ? 16'h0003 : 16'h0000);
            check($sformatf("wr2_rsp_c%0d", c), rsp_valid_o, c == 8);
            check($sformatf("wr2_ready_c%0d", c), req_ready_o, c == 8);
            check($sformatf("wr2_busy_c%0d", c), busy_o, c != 8);
        end
        check("wr2_rdata", rsp_rdata_o, 16'h0000);
        req(1'b0, 3'd2, '0);
        @(negedge clk_i);
        check("rd2_valid", rsp_valid_o, 1'b1);
        check("rd2_rdata", rsp_rdata_o, 16'h0003);

        req(1'b1, 3'd2, 16'h0003);
        @(negedge clk_i);
        check("fast_valid", rsp_valid_o, 1'b1);
        check("fast_quiesce", quiesce_o, '0);
        check("fast_busy", busy_o, 1'b0);
        check("fast_err", rsp_err_o, 1'b0);

        saved_attr = attr_o;
        req(1'b1, 3'd7, 16'hABCD);
        @(negedge clk_i);
        check("oor_wr_valid", rsp_valid_o, 1'b1);
        check("oor_wr_err", rsp_err_o, 1'b1);
        check("oor_wr_rdata", rsp_rdata_o, '0);
        check("oor_wr_attr", attr_o, saved_attr);
        check("oor_wr_quiesce", quiesce_o, '0);
        check("oor_wr_ready", req_ready_o, 1'b1);
        req(1'b0, 3'd6, '0);
        @(negedge clk_i);
        check("oor_rd_err", rsp_err_o, 1'b1);
        check("oor_rd_rdata", rsp_rdata_o, '0);

        // Write pad 4 then keep a read of pad 4 waiting while widening its mask.
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_idx_i   = 3'd4;
        req_wdata_i = 16'h1234;
        @(posedge clk_i);
        #1;
        req_we_i    = 1'b0;
        warl[4]     = 16'hFFFF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            check($sformatf("bp_ready_c%0d", c), req_ready_o, c == 8);
            check($sformatf("bp_rsp_c%0d", c), rsp_valid_o, c == 8);
        end
        check("bp_attr4", attr_w[4], 16'h0034);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_rd_valid", rsp_valid_o, 1'b1);
        check("bp_rd_rdata", rsp_rdata_o, 16'h0034);
        check("bp_quiesce", quiesce_o, '0);

        req(1'b1, 3'd5, 16'hA5A5);
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        check("rstmid_quiesce_pre", quiesce_o, 6'b100000);
        rst_ni = 1'b0;
        #1;
        check("rstmid_quiesce", quiesce_o, '0);
        check("rstmid_attr", attr_o, '0);
        check("rstmid_ready", req_ready_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check($sformatf("rstmid_rsp_c%0d", c), rsp_valid_o, 1'b0);
            check($sformatf("rstmid_q_c%0d", c), quiesce_o, '0);
        end
        check("rstmid_attr_end", attr_o, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
